// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry writeback FIFO plus architectural flags register.
// Compare ops only update flags; all other ops queue {result, dest} for the register file.
package instruction_set;
  parameter int WORD_SIZE = 16;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_INC = 4'd2,
    ALU_DEC = 4'd3,
    ALU_AND = 4'd4,
    ALU_OR  = 4'd5,
    ALU_XOR = 4'd6,
    ALU_CMP = 4'd7,
    ALU_NOT = 4'd8,
    ALU_SHL = 4'd9,
    ALU_SHR = 4'd10,
    ALU_MOV = 4'd11
  } ALU_OPS_T;

  typedef struct packed {
    logic overflow;
    logic carry;
    logic zero;
    logic negative;
  } FLAGS_T;
endpackage

module alu_result_stage
  import instruction_set::*;
#(
  parameter int DEST_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  ALU_OPS_T             in_op,
  input  logic [WORD_SIZE-1:0] in_result,
  input  FLAGS_T               in_flags,
  input  logic [DEST_W-1:0]    in_dest,
  input  logic                 flags_load,
  input  FLAGS_T               flags_load_val,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [WORD_SIZE-1:0] wb_data,
  output logic [DEST_W-1:0]    wb_dest,
  output FLAGS_T               flags_q,
  output logic [15:0]          wb_count
);

  logic [WORD_SIZE-1:0] data_mem [2];
  logic [DEST_W-1:0]    dest_mem [2];
  logic                 rd_ptr_reg;
  logic                 wr_ptr_reg;
  logic [1:0]           occ_reg;
  logic [1:0]           occ_next;
  FLAGS_T               flags_next;

  logic accept;
  logic pop;
  logic push;

  // Readiness depends only on stored occupancy, so a full buffer never
  // accepts even when the register file drains it in the same cycle.
  assign in_ready = (occ_reg != 2'd2) && !rst;
  assign accept   = in_valid && in_ready;
  assign push     = accept && (in_op != ALU_CMP);
  assign wb_valid = (occ_reg != 2'd0);
  assign pop      = wb_valid && wb_ready;
  assign wb_data  = data_mem[rd_ptr_reg];
  assign wb_dest  = dest_mem[rd_ptr_reg];

  always_comb begin
    occ_next = occ_reg;
    case ({push, pop})
      2'b10:   occ_next = occ_reg + 2'd1;
      2'b01:   occ_next = occ_reg - 2'd1;
      default: occ_next = occ_reg;
    endcase
  end

  always_comb begin
    flags_next = flags_q;
    if (flags_load) begin
      flags_next = flags_load_val;
    end else if (accept) begin
      case (in_op)
        ALU_ADD, ALU_SUB, ALU_CMP: begin
          flags_next = in_flags;
        end
        ALU_INC, ALU_DEC, ALU_AND, ALU_OR, ALU_XOR: begin
          flags_next.zero     = in_flags.zero;
          flags_next.negative = in_flags.negative;
        end
        default: begin
          flags_next = flags_q;
        end
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= in_result;
      dest_mem[wr_ptr_reg] <= in_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      occ_reg    <= 2'd0;
      flags_q    <= '0;
      wb_count   <= 16'd0;
    end else begin
      occ_reg <= occ_next;
      flags_q <= flags_next;
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
        wb_count   <= wb_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed-vector bench for alu_result_stage: a queue-based model is checked every
// cycle, and literal expectations taken from the worked examples pin the model.
module tb_alu_result_stage;
  import instruction_set::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  ALU_OPS_T    in_op;
  logic [15:0] in_result;
  FLAGS_T      in_flags;
  logic [2:0]  in_dest;
  logic        flags_load;
  FLAGS_T      flags_load_val;
  logic        wb_valid;
  logic        wb_ready;
  logic [15:0] wb_data;
  logic [2:0]  wb_dest;
  FLAGS_T      flags_q;
  logic [15:0] wb_count;

  int checks = 0;
  int errors = 0;

  alu_result_stage #(.DEST_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_result(in_result), .in_flags(in_flags), .in_dest(in_dest),
    .flags_load(flags_load), .flags_load_val(flags_load_val),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_dest(wb_dest), .flags_q(flags_q), .wb_count(wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a plain queue of pending writebacks, a flags word and a counter.
  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  dst;
  } ent_t;

  ent_t        q[$];
  logic [3:0]  m_flags;
  logic [15:0] m_count;
  bit          live = 0;

  always @(posedge clk) begin
    bit   acc;
    bit   pp;
    ent_t e;
    if (rst) begin
      q.delete();
      m_flags = 4'b0000;
      m_count = 16'd0;
      live = 1;
    end else if (live) begin
      acc = in_valid && (q.size() < 2);
      pp  = (q.size() != 0) && wb_ready;
      if (pp) begin
        void'(q.pop_front());
        m_count = m_count + 16'd1;
      end
      if (acc && in_op != ALU_CMP) begin
        e.d = in_result;
        e.dst = in_dest;
        q.push_back(e);
      end
      if (flags_load) begin
        m_flags = flags_load_val;
      end else if (acc) begin
        if (in_op inside {ALU_ADD, ALU_SUB, ALU_CMP})
          m_flags = in_flags;
        else if (in_op inside {ALU_INC, ALU_DEC, ALU_AND, ALU_OR, ALU_XOR})
          m_flags = {m_flags[3:2], in_flags.zero, in_flags.negative};
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      checks++;
      if (in_ready !== (!rst && q.size() < 2)) begin
        errors++;
        $display("FAIL model_in_ready actual=%b required=%b t=%0t", in_ready, (!rst && q.size() < 2), $time);
      end
      checks++;
      if (wb_valid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL model_wb_valid actual=%b required=%b t=%0t", wb_valid, (q.size() != 0), $time);
      end
      if (q.size() != 0) begin
        checks++;
        if (wb_data !== q[0].d || wb_dest !== q[0].dst) begin
          errors++;
          $display("FAIL model_wb_entry actual=%h/%0d required=%h/%0d t=%0t", wb_data, wb_dest, q[0].d, q[0].dst, $time);
        end
      end
      checks++;
      if (flags_q !== m_flags) begin
        errors++;
        $display("FAIL model_flags actual=%b required=%b t=%0t", flags_q, m_flags, $time);
      end
      checks++;
      if (wb_count !== m_count) begin
        errors++;
        $display("FAIL model_wb_count actual=%0d required=%0d t=%0t", wb_count, m_count, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [15:0] actual, input logic [15:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, actual, required);
    end else begin
      $display("check %s = %h ok", name, actual);
    end
  endtask

  task automatic drive(input ALU_OPS_T op, input logic [15:0] res, input logic [3:0] fl, input logic [2:0] dst);
    in_valid  = 1'b1;
    in_op     = op;
    in_result = res;
    in_flags  = fl;
    in_dest   = dst;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_op = ALU_ADD;
    in_result = 16'h0;
    in_flags = '0;
    in_dest = 3'd0;
    flags_load = 1'b0;
    flags_load_val = '0;
    wb_ready = 1'b0;
    tick();
    tick();
    lit("reset_in_ready", {15'd0, in_ready}, 16'd0);
    lit("reset_wb_valid", {15'd0, wb_valid}, 16'd0);
    lit("reset_flags", {12'd0, flags_q}, 16'd0);
    lit("reset_count", wb_count, 16'd0);
    rst = 1'b0;
    tick();
    lit("post_reset_in_ready", {15'd0, in_ready}, 16'd1);

    // ADD result 0 with C,Z set, dest 3
    wb_ready = 1'b1;
    drive(ALU_ADD, 16'h0000, 4'b0110, 3'd3);
    tick();
    in_valid = 1'b0;
    lit("add_wb_valid", {15'd0, wb_valid}, 16'd1);
    lit("add_wb_data", wb_data, 16'h0000);
    lit("add_wb_dest", {13'd0, wb_dest}, 16'd3);
    lit("add_flags", {12'd0, flags_q}, 16'h0006);
    tick();
    lit("add_count", wb_count, 16'd1);

    // carry/overflow survive a logic op
    flags_load = 1'b1;
    flags_load_val = 4'b1100;
    tick();
    flags_load = 1'b0;
    lit("load_flags", {12'd0, flags_q}, 16'h000C);
    drive(ALU_AND, 16'h8000, 4'b0001, 3'd1);
    tick();
    in_valid = 1'b0;
    lit("and_flags", {12'd0, flags_q}, 16'h000D);
    tick();
    lit("and_count", wb_count, 16'd2);

    // compare: flags only
    drive(ALU_CMP, 16'h0005, 4'b0010, 3'd2);
    tick();
    in_valid = 1'b0;
    lit("cmp_wb_valid", {15'd0, wb_valid}, 16'd0);
    lit("cmp_flags", {12'd0, flags_q}, 16'h0002);

    // backpressure: fill, stall, drain in order
    wb_ready = 1'b0;
    drive(ALU_XOR, 16'h1111, 4'b0000, 3'd4);
    tick();
    drive(ALU_OR, 16'h2222, 4'b0000, 3'd5);
    tick();
    drive(ALU_SUB, 16'h3333, 4'b1001, 3'd6);
    lit("full_in_ready", {15'd0, in_ready}, 16'd0);
    tick();
    lit("full_head", wb_data, 16'h1111);
    wb_ready = 1'b1;
    lit("full_pop_in_ready", {15'd0, in_ready}, 16'd0);
    tick();
    lit("after_pop_in_ready", {15'd0, in_ready}, 16'd1);
    lit("after_pop_head", wb_data, 16'h2222);
    tick();
    in_valid = 1'b0;
    lit("drain_head", wb_data, 16'h3333);
    lit("drain_dest", {13'd0, wb_dest}, 16'd6);
    tick();
    lit("drain_count", wb_count, 16'd5);
    lit("sub_flags", {12'd0, flags_q}, 16'h0009);

    // direct flags load beats same-cycle SUB flags
    wb_ready = 1'b0;
    flags_load = 1'b1;
    flags_load_val = 4'b1010;
    drive(ALU_SUB, 16'h4444, 4'b0101, 3'd7);
    tick();
    flags_load = 1'b0;
    lit("load_prio_flags", {12'd0, flags_q}, 16'h000A);
    lit("load_prio_data", wb_data, 16'h4444);

    // unlisted opcode: pushed, flags held
    drive(ALU_SHL, 16'h5555, 4'b1111, 3'd2);
    tick();
    in_valid = 1'b0;
    lit("shl_flags", {12'd0, flags_q}, 16'h000A);

    // reset with full buffer and competing activity
    rst = 1'b1;
    wb_ready = 1'b1;
    flags_load = 1'b1;
    flags_load_val = 4'b1111;
    drive(ALU_ADD, 16'h6666, 4'b1111, 3'd1);
    tick();
    lit("midrst_wb_valid", {15'd0, wb_valid}, 16'd0);
    lit("midrst_flags", {12'd0, flags_q}, 16'h0000);
    lit("midrst_count", wb_count, 16'd0);
    lit("midrst_in_ready", {15'd0, in_ready}, 16'd0);
    rst = 1'b0;
    flags_load = 1'b0;
    in_valid = 1'b0;
    tick();
    lit("midrst_after_in_ready", {15'd0, in_ready}, 16'd1);

    // counter wrap: 65537 pops leave the count at 1
    wb_ready = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      drive(ALU_MOV, i[15:0], 4'b0000, i[2:0]);
      tick();
    end
    in_valid = 1'b0;
    tick();
    lit("wrap_count", wb_count, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter: WORD_SIZE, from instruction_set package (16); datapath width of result and writeback data.
REQ-002 Parameter: DEST_W, default 3; width of register-file destination index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  ALU output bundle present this cycle.
REQ-006 in_ready  output  1  stage accepts bundle this cycle.
REQ-007 in_op  input  ALU_OPS_T  operation that produced the bundle.
REQ-008 in_result  input  WORD_SIZE  ALU result.
REQ-009 in_flags  input  FLAGS_T  ALU flags (overflow, carry, zero, negative).
REQ-010 in_dest  input  DEST_W  destination register index.
REQ-011 flags_load  input  1  direct architectural flags write request.
REQ-012 flags_load_val  input  FLAGS_T  value for direct flags write.
REQ-013 wb_valid  output  1  writeback entry available.
REQ-014 wb_ready  input  1  register file consumes entry.
REQ-015 wb_data  output  WORD_SIZE  writeback data.
REQ-016 wb_dest  output  DEST_W  writeback register index.
REQ-017 flags_q  output  FLAGS_T  architectural flags register.
REQ-018 wb_count  output  16  count of retired writebacks, wraps.

Function
REQ-019 Accept = in_valid && in_ready; pop = wb_valid && wb_ready.
REQ-020 Writeback buffer: 2-entry FIFO of {data, dest}; occupancy 0..2.
REQ-021 in_ready = (occupancy < 2) && !rst; registered-state only, no combinational path from wb_ready or in_valid.
REQ-022 Full (occupancy 2) with simultaneous pop: in_ready stays 0 that cycle; occupancy becomes 1 next cycle.
REQ-023 Accepted ALU_CMP: no FIFO push; flags update only.
REQ-024 Accepted any other op: push {in_result, in_dest}; push and pop same cycle leave occupancy unchanged, order preserved.
REQ-025 wb_valid = occupancy != 0; wb_data/wb_dest = oldest entry; outputs stable while wb_valid && !wb_ready.
REQ-026 Empty FIFO: push visible on wb_valid next cycle (1-cycle latency); no bypass.
REQ-027 Flags on accept, ALU_ADD/ALU_SUB/ALU_CMP: flags_q <= in_flags (all four bits).
REQ-028 Flags on accept, ALU_INC/ALU_DEC/ALU_AND/ALU_OR/ALU_XOR: zero, negative <= in_flags; carry, overflow hold.
REQ-029 Flags on accept, any other op encoding: flags_q holds; result still pushed.
REQ-030 flags_load: flags_q <= flags_load_val next edge; takes priority over same-cycle accept flag update (accept still pushes).
REQ-031 in_valid without accept: no state change; upstream holds bundle.
REQ-032 wb_count increments by 1 per pop; 16'hFFFF wraps to 0.

Reset
REQ-033 rst sampled high: occupancy 0, wb_valid 0, flags_q 0, wb_count 0, in_ready 0 during reset cycle, 1 first cycle after.
REQ-034 Reset mid-operation: buffered entries discarded without pop; same-cycle accept, pop, flags_load ignored.
REQ-035 wb_data/wb_dest values undefined while wb_valid 0; checked only when wb_valid 1.

Verification
REQ-036 ADD result 16'h0000, flags {V=0,C=1,Z=1,N=0}, dest 3, wb_ready 1 -> next cycle wb_valid 1, wb_data 0, wb_dest 3; flags_q C=1,Z=1; wb_count 1 after pop.
REQ-037 flags_q C=1,V=1, then AND result 16'h8000 flags {N=1} -> flags_q {V=1,C=1,Z=0,N=1}.
REQ-038 CMP result 16'h0005 -> no wb_valid, flags_q = in_flags, occupancy 0.
REQ-039 wb_ready 0, three back-to-back ops -> two accepted, in_ready 0; wb_ready 1 with full FIFO -> in_ready 0 that cycle, 1 next; entries drain in order.
REQ-040 flags_load val 4'b1010 with SUB accept same cycle -> flags_q 4'b1010, SUB result still pushed.
REQ-041 rst asserted with occupancy 2 -> next cycle wb_valid 0, flags_q 0, wb_count 0, in_ready 1 cycle after reset deasserts.
